// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - store write buffer with in-order memory drain and load forwarding
//
// Purpose: holds up to DEPTH pipeline stores in a circular FIFO, writes them to
// the memory port oldest-first whenever the cache fill logic is not using it,
// spaces consecutive writes with WR_GAP idle cycles, and forwards the youngest
// buffered store data to a load hitting the same word address.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   enq_valid/addr/data   store request from the pipeline
//   full, empty, count    occupancy status (registered state only)
//   mem_busy              memory port owned by cache fill logic
//   mem_wen/addr/data     one-cycle write strobe and payload (zero when idle)
//   ld_addr               load address to check against buffered stores
//   fwd_hit, fwd_data     forwarding result (combinational)

module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int WR_GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  input  logic [15:0]            enq_addr,
  input  logic [15:0]            enq_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   mem_busy,
  output logic                   mem_wen,
  output logic [15:0]            mem_addr,
  output logic [15:0]            mem_data,
  input  logic [15:0]            ld_addr,
  output logic                   fwd_hit,
  output logic [15:0]            fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [15:0]   addr_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [1:0]    state;
  logic [2:0]    gap_cnt;
  logic          push;
  logic          pop;
  logic [PW-1:0] fwd_idx;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0) && (state == ST_IDLE);

  // A full buffer ignores the request; the requester holds it until full falls.
  assign push = enq_valid && !full;
  // The head entry is consumed at the end of its single ISSUE cycle.
  assign pop  = (state == ST_ISSUE);

  assign mem_wen  = (state == ST_ISSUE);
  assign mem_addr = mem_wen ? addr_q[head] : 16'h0000;
  assign mem_data = mem_wen ? data_q[head] : 16'h0000;

  // Entry payloads are not reset; validity comes only from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= enq_addr;
      data_q[tail] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      case (state)
        ST_IDLE: begin
          if (count != '0 && !mem_busy) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (WR_GAP > 0) begin
            state   <= ST_GAP;
            gap_cnt <= 3'(WR_GAP);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt <= 3'd1) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Scan valid slots oldest to youngest so the last match (youngest) wins.
  // The head stays valid through its ISSUE cycle; a same-cycle enqueue is
  // not yet counted and therefore never compared.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 16'h0000;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[fwd_idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries; power of two, 2..16.
REQ-002 Parameter WR_GAP, default 1, idle cycles the block inserts after each memory write before the next; range 0..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 enq_valid  input  1  pipeline store request, sampled each rising edge.
REQ-006 enq_addr  input  16  store word address.
REQ-007 enq_data  input  16  store data.
REQ-008 full  output  1  buffer holds DEPTH entries; pipeline stalls stores while high.
REQ-009 empty  output  1  buffer holds zero entries and drain FSM is in IDLE.
REQ-010 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 mem_busy  input  1  memory port owned by the cache fill logic (I or D fill in progress).
REQ-012 mem_wen  output  1  one-cycle write strobe to the memory port.
REQ-013 mem_addr  output  16  write address, valid while mem_wen=1, else 0.
REQ-014 mem_data  output  16  write data, valid while mem_wen=1, else 0.
REQ-015 ld_addr  input  16  load address from the data-side stage, for forwarding.
REQ-016 fwd_hit  output  1  combinational: some valid entry has address equal to ld_addr.
REQ-017 fwd_data  output  16  data of the youngest matching entry when fwd_hit=1, else 0.

Function
REQ-018 Storage is a circular FIFO of DEPTH {addr,data} entries, with head (oldest) and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-019 Enqueue occurs on a rising edge when enq_valid=1 and count<DEPTH at that edge: entry is written at tail, tail advances, and count increments.
REQ-020 enq_valid=1 while count=DEPTH is ignored: no state change and no overwrite; the requester holds the store until full falls.
REQ-021 full = (count==DEPTH); empty = (count==0 && state==IDLE); both are derived from registered state with no combinational path from inputs.
REQ-022 Drain FSM states: IDLE, ISSUE, GAP.
REQ-023 IDLE->ISSUE when count>0 and mem_busy=0 at the edge; otherwise the FSM stays in IDLE.
REQ-024 In ISSUE, mem_wen=1, mem_addr/mem_data come from the head entry, and at the end of the cycle the head advances and count decrements; ISSUE lasts exactly one cycle and is never aborted by mem_busy.
REQ-025 ISSUE->GAP when WR_GAP>0, loading a gap counter with WR_GAP; ISSUE->IDLE when WR_GAP=0.
REQ-026 GAP decrements the gap counter each cycle and goes to IDLE after WR_GAP cycles; mem_wen=0 throughout GAP.
REQ-027 Simultaneous enqueue and ISSUE pop in one cycle leave count unchanged, and both pointers advance.
REQ-028 An entry enqueued into an empty buffer is not written to memory in the same cycle; the earliest ISSUE is the following cycle.
REQ-029 Write order to memory equals enqueue order.
REQ-030 Forwarding compares ld_addr against all valid entries, including the head entry during its ISSUE cycle; the same-cycle enqueue is not compared.
REQ-031 With multiple matches, fwd_data is taken from the entry closest to the tail (youngest).
REQ-032 Entries hold stale values after pop; only valid slots, determined by head/count, participate in forwarding.

Reset
REQ-033 When rst=0, the block asynchronously clears head, tail, count, the gap counter and the entry valid state, and forces the FSM to IDLE.
REQ-034 Output values during and after reset: mem_wen=0, mem_addr=0, mem_data=0, full=0, empty=1, count=0, fwd_hit=0, fwd_data=0.
REQ-035 Reset asserted mid-ISSUE drops mem_wen immediately; all pending stores are discarded.
REQ-036 After rst returns to 1, the first enqueue is accepted on the next rising edge.

Verification
REQ-037 Single store: enq {0x0010,0xBEEF}, mem_busy=0 -> next cycle mem_wen=1, addr 0x0010, data 0xBEEF for one cycle; with WR_GAP=1, empty=1 two cycles later.
REQ-038 Fill: mem_busy=1, five consecutive enqueues with DEPTH=4 -> count=4, full=1, fifth enqueue ignored; release mem_busy -> four writes in order, each separated by WR_GAP idle cycles.
REQ-039 Wrap: enqueue and drain 10 stores through DEPTH=4 with interleaved mem_busy pulses -> memory write sequence equals enqueue sequence and pointers wrap correctly.
REQ-040 Forwarding: buffer holds {0x20,0x1111} then {0x20,0x2222}; ld_addr=0x20 -> fwd_hit=1, fwd_data=0x2222; ld_addr=0x30 -> fwd_hit=0, fwd_data=0.
REQ-041 Simultaneous: count=4 and ISSUE in progress with enq_valid=1 -> enqueue rejected (count was 4 at the edge), count=3 afterward; the same test at count=2 -> count stays 2.
REQ-042 Reset mid-drain: rst=0 during ISSUE with count=3 -> mem_wen falls without waiting for a clock edge, count=0, empty=1, and no further writes after rst=1.
